// File: rtl/instr_encoder.sv
// Instruction encoder: turns symbolic ops into 32-bit MIPS-style words and streams them
// into instruction memory from address 0. Optional illegal-op trap: INSTR_ENC_ILLEGAL_TRAP_EN.
module instr_encoder #(
  parameter int ADDR_WIDTH_P = 6
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_start,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [3:0]              i_op,
  input  logic [4:0]              i_rs,
  input  logic [4:0]              i_rt,
  input  logic [4:0]              i_rd,
  input  logic [15:0]             i_imm,
  input  logic [25:0]             i_target,
  output logic                    o_imem_wr_en,
  output logic [ADDR_WIDTH_P-1:0] o_imem_addr,
  output logic [31:0]             o_imem_wr_data,
  output logic                    o_full,
  output logic                    o_err
);

`ifdef INSTR_ENC_ILLEGAL_TRAP_EN
  typedef enum logic [1:0] {IDLE, LOAD, FULL, ERR} state_t;
`else
  typedef enum logic [1:0] {IDLE, LOAD, FULL} state_t;
`endif

  state_t                  state_q;
  logic [ADDR_WIDTH_P-1:0] addr_q;
  logic                    wr_en_q;
  logic [ADDR_WIDTH_P-1:0] waddr_q;
  logic [31:0]             wdata_q;
  logic                    full_q;
  logic [31:0]             word_d;
  logic                    legal_d;
  logic                    hs;

  // start suppresses ready so a same-cycle beat is never accepted
  assign o_ready = (state_q == LOAD) && !i_start;
  assign hs      = i_valid && o_ready;

  always_comb begin
    word_d  = 32'h0;
    legal_d = 1'b1;
    case (i_op)
      4'd0: word_d = {6'b000000, i_rs, i_rt, i_rd, 5'b00000, 6'b100000};
      4'd1: word_d = {6'b000000, i_rs, i_rt, i_rd, 5'b00000, 6'b100010};
      4'd2: word_d = {6'b000000, i_rs, i_rt, i_rd, 5'b00000, 6'b100100};
      4'd3: word_d = {6'b000000, i_rs, i_rt, i_rd, 5'b00000, 6'b100101};
      4'd4: word_d = {6'b000000, i_rs, i_rt, i_rd, 5'b00000, 6'b101010};
      4'd5: word_d = {6'b100011, i_rs, i_rt, i_imm};
      4'd6: word_d = {6'b101011, i_rs, i_rt, i_imm};
      4'd7: word_d = {6'b000100, i_rs, i_rt, i_imm};
      4'd8: word_d = {6'b000010, i_target};
      default: legal_d = 1'b0;
    endcase
  end

`ifdef INSTR_ENC_ILLEGAL_TRAP_EN
  logic err_q;
  assign o_err = err_q;
`else
  assign o_err = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wr_en_q <= 1'b0;
      waddr_q <= '0;
      wdata_q <= 32'h0;
      full_q  <= 1'b0;
`ifdef INSTR_ENC_ILLEGAL_TRAP_EN
      err_q   <= 1'b0;
`endif
    end else begin
      wr_en_q <= 1'b0;
      if (i_start) begin
        state_q <= LOAD;
        addr_q  <= '0;
        full_q  <= 1'b0;
`ifdef INSTR_ENC_ILLEGAL_TRAP_EN
        err_q   <= 1'b0;
`endif
      end else if (hs) begin
        if (legal_d) begin
          wr_en_q <= 1'b1;
          waddr_q <= addr_q;
          wdata_q <= word_d;
          // last address: stop here instead of wrapping
          if (&addr_q) begin
            state_q <= FULL;
            full_q  <= 1'b1;
          end else begin
            addr_q  <= addr_q + 1'b1;
          end
        end else begin
`ifdef INSTR_ENC_ILLEGAL_TRAP_EN
          state_q <= ERR;
          err_q   <= 1'b1;
`endif
        end
      end
    end
  end

  assign o_imem_wr_en   = wr_en_q;
  assign o_imem_addr    = waddr_q;
  assign o_imem_wr_data = wdata_q;
  assign o_full         = full_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder with a cycle-level reference model and literal spot checks.
module tb_instr_encoder;
  localparam int AW    = 2;
  localparam int DEPTH = 1 << AW;

  logic          i_clk = 0, i_rst = 0, i_start = 0, i_valid = 0;
  logic [3:0]    i_op = 0;
  logic [4:0]    i_rs = 0, i_rt = 0, i_rd = 0;
  logic [15:0]   i_imm = 0;
  logic [25:0]   i_target = 0;
  logic          o_ready, o_imem_wr_en, o_full, o_err;
  logic [AW-1:0] o_imem_addr;
  logic [31:0]   o_imem_wr_data;

  int checks = 0, errors = 0;

  instr_encoder #(.ADDR_WIDTH_P(AW)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_valid(i_valid), .o_ready(o_ready),
    .i_op(i_op), .i_rs(i_rs), .i_rt(i_rt), .i_rd(i_rd), .i_imm(i_imm), .i_target(i_target),
    .o_imem_wr_en(o_imem_wr_en), .o_imem_addr(o_imem_addr), .o_imem_wr_data(o_imem_wr_data),
    .o_full(o_full), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference encoding from opcode/funct tables and field shifts
  function automatic logic [31:0] enc(input int op, input int rs, input int rt, input int rd,
                                      input int imm, input int tgt);
    int funct_t [5] = '{32, 34, 36, 37, 42};
    int opc_t   [3] = '{35, 43, 4};
    if (op <= 4) return (rs << 21) | (rt << 16) | (rd << 11) | funct_t[op];
    if (op <= 7) return (opc_t[op-5] << 26) | (rs << 21) | (rt << 16) | (imm & 32'hFFFF);
    return (2 << 26) | (tgt & 32'h3FFFFFF);
  endfunction

  // Model: mode 0 idle, 1 loading, 2 full, 3 trapped
  int m_mode = 0, m_next = 0;
  logic m_wr = 0, m_full = 0, m_err = 0;
  int m_addr = 0;
  logic [31:0] m_data = 0;

  always @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      m_mode = 0; m_next = 0; m_wr = 0; m_full = 0; m_err = 0; m_addr = 0; m_data = 0;
    end else begin
      m_wr = 0;
      if (i_start) begin
        m_mode = 1; m_next = 0; m_full = 0; m_err = 0;
      end else if (m_mode == 1 && i_valid) begin
        if (i_op <= 8) begin
          m_wr = 1; m_addr = m_next;
          m_data = enc(i_op, i_rs, i_rt, i_rd, i_imm, i_target);
          if (m_next == DEPTH - 1) begin m_mode = 2; m_full = 1; end
          else m_next++;
        end else begin
`ifdef INSTR_ENC_ILLEGAL_TRAP_EN
          m_mode = 3; m_err = 1;
`endif
        end
      end
    end
  end

  always @(negedge i_clk) begin
    if (!i_rst) begin
      chk("m_wr_en", 32'(o_imem_wr_en), 32'(m_wr));
      chk("m_full",  32'(o_full),       32'(m_full));
      chk("m_err",   32'(o_err),        32'(m_err));
      chk("m_ready", 32'(o_ready),      32'(m_mode == 1 && !i_start));
      if (m_wr) begin
        chk("m_addr", 32'(o_imem_addr), 32'(m_addr));
        chk("m_data", o_imem_wr_data,   m_data);
      end
    end
  end

  task automatic tick();
    @(posedge i_clk); #1;
  endtask

  task automatic beat(input int op, input int rs, input int rt, input int rd,
                      input int imm, input int tgt);
    i_valid = 1; i_op = 4'(op); i_rs = 5'(rs); i_rt = 5'(rt); i_rd = 5'(rd);
    i_imm = 16'(imm); i_target = 26'(tgt);
  endtask

  task automatic start_pulse();
    i_valid = 0; i_start = 1; tick(); i_start = 0;
  endtask

  initial begin
    #1 i_rst = 1;
    #1;
    chk("rst_wr_en", 32'(o_imem_wr_en), 0);
    chk("rst_addr",  32'(o_imem_addr),  0);
    chk("rst_data",  o_imem_wr_data,    0);
    chk("rst_ready", 32'(o_ready),      0);
    tick(); tick(); i_rst = 0;

    // Idle ignores beats until start
    beat(0, 1, 2, 3, 0, 0); tick(); tick();
    chk("idle_nowr", 32'(o_imem_wr_en), 0);

    start_pulse();
    beat(0, 1, 2, 3, 0, 0); tick(); i_valid = 0;
    chk("add_wr", 32'(o_imem_wr_en), 1);
    chk("add_addr", 32'(o_imem_addr), 0);
    chk("add_data", o_imem_wr_data, 32'h00221820);
    tick();

    start_pulse();
    beat(5, 0, 8, 0, 'h0004, 0); tick();
    chk("lw_addr", 32'(o_imem_addr), 0); chk("lw_data", o_imem_wr_data, 32'h8C080004);
    beat(7, 1, 2, 0, 'hFFFF, 0); tick();
    chk("beq_addr", 32'(o_imem_addr), 1); chk("beq_data", o_imem_wr_data, 32'h1022FFFF);
    beat(8, 0, 0, 0, 0, 'h10); tick(); i_valid = 0;
    chk("j_addr", 32'(o_imem_addr), 2); chk("j_data", o_imem_wr_data, 32'h08000010);
    chk("j_wr", 32'(o_imem_wr_en), 1);
    tick();

    // Fill all four words
    start_pulse();
    for (int k = 0; k < 4; k++) begin beat(4, 4, 5, 6, 0, 0); tick(); end
    chk("slt4_addr", 32'(o_imem_addr), 3); chk("slt4_data", o_imem_wr_data, 32'h0085302A);
    chk("slt4_full", 32'(o_full), 1); chk("slt4_ready", 32'(o_ready), 0);
    tick();
    chk("slt5_nowr", 32'(o_imem_wr_en), 0);
    start_pulse();
    chk("restart_full", 32'(o_full), 0);
    beat(1, 7, 8, 9, 0, 0); tick(); i_valid = 0;
    chk("restart_addr", 32'(o_imem_addr), 0); chk("restart_wr", 32'(o_imem_wr_en), 1);
    tick();

    // Illegal op
    start_pulse();
    beat(0, 1, 2, 3, 0, 0); tick();
    beat(12, 1, 2, 3, 0, 0); tick();
    chk("ill_nowr", 32'(o_imem_wr_en), 0);
    beat(2, 3, 4, 5, 0, 0); tick(); i_valid = 0;
`ifdef INSTR_ENC_ILLEGAL_TRAP_EN
    chk("ill_err", 32'(o_err), 1); chk("ill_ready", 32'(o_ready), 0);
    chk("ill_blk", 32'(o_imem_wr_en), 0);
`else
    chk("ill_err", 32'(o_err), 0); chk("ill_next_addr", 32'(o_imem_addr), 1);
    chk("ill_next_wr", 32'(o_imem_wr_en), 1);
`endif
    tick();

    // Start with valid: beat dropped
    start_pulse();
    beat(3, 1, 1, 1, 0, 0); i_start = 1; tick(); i_start = 0; i_valid = 0;
    chk("sv_nowr", 32'(o_imem_wr_en), 0);
    tick();

    // Start during a pending write: old address kept, next beat at 0
    beat(6, 2, 3, 0, 'h10, 0); tick();
    beat(6, 2, 3, 0, 'h10, 0); tick();
    i_valid = 0; i_start = 1;
    chk("pend_addr", 32'(o_imem_addr), 1); chk("pend_wr", 32'(o_imem_wr_en), 1);
    tick(); i_start = 0;
    beat(6, 2, 3, 0, 'h10, 0); tick(); i_valid = 0;
    chk("pend_new_addr", 32'(o_imem_addr), 0);
    chk("pend_new_data", o_imem_wr_data, 32'hAC430010);

    // Async reset mid-write
    #1 i_rst = 1; #1;
    chk("arst_wr", 32'(o_imem_wr_en), 0); chk("arst_data", o_imem_wr_data, 0);
    chk("arst_addr", 32'(o_imem_addr), 0); chk("arst_ready", 32'(o_ready), 0);
    tick(); i_rst = 0;
    beat(0, 1, 2, 3, 0, 0); tick(); i_valid = 0;
    chk("arst_idle", 32'(o_imem_wr_en), 0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
